// File: rtl/gray_sched_pkg.sv
// -----------------------------------------------------------------------------
// gray_sched_pkg
//   Shared types and constants for the Gray-decode scheduler.
//   - state_t   : scheduler FSM states (IDLE, LOAD, PRESENT)
//   - N_CH_DEF  : default number of requesting channels
//   - W_DEF     : default Gray/binary word width
//   - ch_width  : width of a channel index (clog2, never below 1)
// -----------------------------------------------------------------------------
package gray_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 4;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gray2bin_w.sv
// -----------------------------------------------------------------------------
// gray2bin_w
//   Combinational W-bit Gray-to-binary converter. Each binary bit is the XOR
//   of all Gray bits at or above its position.
//   Ports:
//     g_i : Gray-coded input word
//     b_o : binary output word
// -----------------------------------------------------------------------------
module gray2bin_w #(
    parameter int W = 4
) (
    input  logic [W-1:0] g_i,
    output logic [W-1:0] b_o
);

    // Running XOR from the MSB down avoids reading b_o back inside the block.
    always_comb begin
        logic acc;
        acc = 1'b0;
        b_o = '0;
        for (int k = W - 1; k >= 0; k--) begin
            acc    = acc ^ g_i[k];
            b_o[k] = acc;
        end
    end

endmodule

// File: rtl/gray_decode_scheduler.sv
// -----------------------------------------------------------------------------
// gray_decode_scheduler
//   Round-robin scheduler sharing one registered Gray-to-binary stage among
//   N_CH channels. Requests are latched per channel, arbitrated fairly,
//   converted and presented on a valid/ready port.
//   Ports:
//     clk         : clock, rising edge
//     rst_n       : asynchronous active-low reset
//     req         : per-channel request strobe
//     gray_in     : channel i Gray word at [i*W +: W]
//     overrun_clr : per-channel clear of the sticky overrun flag
//     out_valid   : result available
//     out_ready   : consumer accepts the result
//     out_ch      : channel index of the result
//     out_bin     : converted binary value
//     overrun     : sticky flag, a request was overwritten while pending
//     busy        : FSM is not in IDLE
// -----------------------------------------------------------------------------
module gray_decode_scheduler
    import gray_sched_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*W-1:0] gray_in,
    input  logic [N_CH-1:0]   overrun_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [W-1:0]      out_bin,
    output logic [N_CH-1:0]   overrun,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   overrun_q, overrun_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   sel_q, sel_c;
    logic [W-1:0]      hold_q [N_CH];
    logic [W-1:0]      conv_in_q;
    logic [W-1:0]      conv_bin;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [W-1:0]      out_bin_q;
    logic              grant;
    logic              load_en;
    logic              ack;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q) state_d = LOAD;
            LOAD:    state_d = PRESENT;
            PRESENT: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        grant   = (state_q == IDLE) && (|pending_q);
        load_en = (state_q == LOAD);
        ack     = (state_q == PRESENT) && out_valid_q && out_ready;
        busy    = (state_q != IDLE);
    end

    // Round-robin search: first pending index at or after rr, wrapping.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        sel_c = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel_c = CH_W'(idx);
            end
        end
    end

    // Capture and overrun bookkeeping. A request arriving for the channel
    // being granted re-arms pending with the new word and is not an overrun,
    // because the old word is consumed by this grant.
    always_comb begin
        logic hit;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < N_CH; i++) begin
            hit = grant && (int'(sel_c) == i);
            if (hit)            pending_d[i] = 1'b0;
            if (req[i])         pending_d[i] = 1'b1;
            if (overrun_clr[i]) overrun_d[i] = 1'b0;
            if (req[i] && pending_q[i] && !hit) overrun_d[i] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (int'(sel_c) == N_CH - 1) ? '0 : sel_c + CH_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            rr_q        <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_bin_q   <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_q      <= rr_d;
            if (grant) sel_q <= sel_c;
            if (load_en) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= sel_q;
                out_bin_q   <= conv_bin;
            end else if (ack) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Word storage carries no reset: it is only consumed behind pending.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (req[i]) hold_q[i] <= gray_in[i*W +: W];
        end
        if (grant) conv_in_q <= hold_q[sel_c];
    end

    gray2bin_w #(.W(W)) u_g2b (
        .g_i (conv_in_q),
        .b_o (conv_bin)
    );

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_bin   = out_bin_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gray_decode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gray_decode_scheduler
//   Directed self-checking bench for gray_decode_scheduler (N_CH=4, W=4).
// -----------------------------------------------------------------------------
module tb_gray_decode_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] gray_in;
    logic [3:0]  overrun_clr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [3:0]  out_bin;
    logic [3:0]  overrun;
    logic        busy;

    int tests;
    int fails;

    gray_decode_scheduler #(.N_CH(4), .W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gray_in     (gray_in),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_bin     (out_bin),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_gray(input int ch, input logic [3:0] v);
        gray_in[ch*4 +: 4] = v;
    endtask

    // Reference: each binary bit is XOR of all Gray bits at or above it.
    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Wait (bounded) for a result with out_ready high, check it, let it handshake.
    task automatic get_result(input string tag, input logic [1:0] ech, input logic [3:0] ebin);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ch"}, out_ch, ech);
        chk({tag, "_bin"}, out_bin, ebin);
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req = '0;
        gray_in = '0;
        overrun_clr = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bin", out_bin, 0);
        chk("rst_ch", out_ch, 0);
        rst_n = 1'b1;
        tick();

        // Fairness: all four at once, rr starts at 0
        set_gray(0, 4'b0000);
        set_gray(1, 4'b0011);
        set_gray(2, 4'b0110);
        set_gray(3, 4'b1100);
        req = 4'b1111;
        tick();
        req = '0;
        get_result("fair0", 2'd0, 4'b0000);
        get_result("fair1_wait", 2'd1, 4'b0010);
        // ch1 presented (granted); re-request ch0 and ch3 during its handshake.
        // ch3 is still pending, so that repeat is an overrun.
        set_gray(0, 4'b0111);
        set_gray(3, 4'b1110);
        req = 4'b1001;
        tick();
        req = '0;
        get_result("fair2", 2'd2, 4'b0100);
        get_result("fair3", 2'd3, 4'b1011);
        get_result("fair0b", 2'd0, 4'b0101);
        chk("fair_overrun", overrun, 4'b1000);
        overrun_clr = 4'b1000;
        tick();
        overrun_clr = '0;
        chk("fair_ovr_clr", overrun, 4'b0000);

        // Single request with exact latency (rr is now 1)
        set_gray(2, 4'b1101);
        req = 4'b0100;
        tick();
        req = '0;
        chk("single_e0_valid", out_valid, 0);
        chk("single_e0_busy", busy, 0);
        tick();
        chk("single_e1_busy", busy, 1);
        chk("single_e1_valid", out_valid, 0);
        tick();
        chk("single_e2_valid", out_valid, 1);
        chk("single_ch", out_ch, 2);
        chk("single_bin", out_bin, 4'b1001);
        tick();
        chk("single_onecycle", out_valid, 0);
        chk("single_idle", busy, 0);

        // Backpressure and overrun
        out_ready = 1'b0;
        set_gray(0, 4'b0101);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        chk("bp_valid", out_valid, 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                set_gray(1, 4'b0011);
                req = 4'b0010;
            end else if (c == 1) begin
                set_gray(1, 4'b1000);
                req = 4'b0010;
            end else begin
                req = '0;
            end
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ch", out_ch, 0);
            chk("bp_hold_bin", out_bin, 4'b0110);
            chk("bp_busy", busy, 1);
        end
        chk("bp_overrun", overrun, 4'b0010);
        out_ready = 1'b1;
        tick();
        get_result("bp_ch1", 2'd1, 4'b1111);
        overrun_clr = 4'b0010;
        tick();
        overrun_clr = '0;
        chk("bp_ovr_clr", overrun, 4'b0000);

        // Collision: new req[0] in ch0's grant cycle
        set_gray(0, 4'b0001);
        req = 4'b0001;
        tick();
        set_gray(0, 4'b0010);
        req = 4'b0001;
        tick();
        req = '0;
        get_result("coll_old", 2'd0, 4'b0001);
        get_result("coll_new", 2'd0, 4'b0011);
        chk("coll_overrun", overrun, 4'b0000);

        // Exhaustive codes on ch3
        for (int g = 0; g < 16; g++) begin
            set_gray(3, 4'(g));
            req = 4'b1000;
            tick();
            req = '0;
            get_result("exh", 2'd3, ref_g2b(4'(g)));
        end
        chk("exh_ref_1000", ref_g2b(4'b1000), 4'b1111);

        // Reset mid-PRESENT with pending work and a set overrun
        out_ready = 1'b0;
        set_gray(1, 4'b0100);
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        tick();
        chk("rmid_valid", out_valid, 1);
        chk("rmid_bin", out_bin, 4'b0111);
        set_gray(2, 4'b0001);
        req = 4'b0100;
        tick();
        req = 4'b0100;
        overrun_clr = 4'b0100;
        tick();
        req = '0;
        overrun_clr = '0;
        chk("set_wins", overrun, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_async_valid", out_valid, 0);
        chk("rmid_async_busy", busy, 0);
        chk("rmid_async_overrun", overrun, 0);
        chk("rmid_async_bin", out_bin, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rpost_valid", out_valid, 0);
            chk("rpost_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
